spi_adc_responder: RTL and testbench
====================================

# spi_adc_responder

SPI responder that emulates the 12-bit ADC on the board's serial sample link, so the sample-capture path (the SPI initiator that drives `spi_clock` and `spi_chipselect` and reads `spi_data`) can be exercised with known data in simulation and in loopback builds. Samples arrive on an AXI4-Stream slave port and are buffered in a small FIFO. Each chip-select frame shifts one buffered sample out MSB-first, behind leading zeros. The block runs on the system PLL clock and oversamples the SPI lines.

## Interface
- `C_S00_AXIS_TDATA_WIDTH`, 16, stream word width; only the low `DATA_BITS` bits are transmitted
- `FIFO_ADDR_WIDTH`, 4, FIFO depth = 2**FIFO_ADDR_WIDTH words
- `FRAME_BITS`, 16, SPI clocks per frame
- `DATA_BITS`, 12, payload bits; leading zeros = FRAME_BITS-DATA_BITS
- `IDLE_SAMPLE`, 12'h800, payload sent when the FIFO is empty at frame start
- `s00_axis_aclk`  in  1  system clock; all logic on rising edge
- `s00_axis_aresetn`  in  1  asynchronous, active-low reset
- `s00_axis_tdata`  in  C_S00_AXIS_TDATA_WIDTH  sample word
- `s00_axis_tstrb`  in  C_S00_AXIS_TDATA_WIDTH/8  ignored
- `s00_axis_tvalid`  in  1  word valid
- `s00_axis_tready`  out  1  high when FIFO not full
- `spi_clock`  in  1  initiator SCLK, asynchronous to aclk
- `spi_chipselect`  in  1  initiator CS, active low, asynchronous
- `spi_data`  out  1  serial data, registered
- `fifo_level`  out  FIFO_ADDR_WIDTH+1  words buffered
- `underflow_count`  out  8  frames started on empty FIFO, saturates at 255
- `abort_count`  out  8  frames ended early by CS rise, saturates at 255

## Operation
- Reset values: `s00_axis_tready`=0 while reset is asserted and 1 from the first cycle after release; `spi_data`=0; `fifo_level`=0; both counters 0; FIFO empty; synchronizers for `spi_clock` and `spi_chipselect` preset to 1; state IDLE.
- Synchronizers: 2-flop chain per SPI input plus one history flop. An edge is the difference between stage 2 and history.
- FIFO: push on `tvalid && tready`. Pop only at frame start. Push and pop in the same cycle are both performed and `fifo_level` is unchanged. No bypass: a word pushed in the cycle that a frame starts on an empty FIFO is not sent in that frame.
- States:
  - IDLE: `spi_data`=0. On a CS falling edge, load the shift register with {zeros, payload}, where payload = FIFO head[DATA_BITS-1:0] (popped) or IDLE_SAMPLE if the FIFO is empty (`underflow_count`++). Drive `spi_data` = shift register MSB (a leading 0). Bit counter = 0. Go to SHIFT.
  - SHIFT: on each SCLK falling edge while CS is low, shift left, drive the new MSB, bit counter++. When the counter reaches FRAME_BITS-1, go to HOLD. SCLK rising edges are ignored; the initiator samples on them.
  - HOLD: `spi_data` holds the last (LSB) bit until the next SCLK falling edge, then drives 0. Remain until CS rises.
  - Any state, CS rising edge: `spi_data`=0, go to IDLE. If it occurs in SHIFT, `abort_count`++ and the popped sample is discarded, not re-queued.
- CS falling and SCLK falling in the same cycle: the frame load takes priority and that SCLK edge is ignored.
- Counters saturate at 255 and clear only on reset.
- Asserting reset mid-frame clears the FIFO and counters immediately and returns to IDLE.

## Timing
- `spi_data` changes on the 3rd aclk rising edge after the first aclk edge that samples the new SPI pin level (2 sync stages + 1 output register).
- Initiator requirements, stated for integration only (not checked by this block):
  - SCLK high and low phases of at least 4 aclk cycles each.
  - At least 4 aclk cycles from CS fall to the first SCLK rise.
  - These hold with the capture path's clock divider of 8.
- `s00_axis_tready` is combinational from the FIFO-full flag. It drops in the cycle after a push fills the FIFO and rises in the cycle after a pop from a full FIFO.
- `fifo_level` and the counters update one cycle after the causing event.

## Test plan
- Reset release, then push 0x0ABC and run one 16-clock frame (SCLK period 16 aclk) → initiator captures 16'h0ABC; `fifo_level` goes 1→0; counters stay 0.
- Frame on an empty FIFO → captures 16'h0800; `underflow_count`=1. Repeat 300 frames → `underflow_count`=255.
- Push 0x123, 0x456, 0x789 back-to-back, then run three frames → captures 0x0123, 0x0456, 0x0789 in order.
- Push 17 words with `tvalid` held high → 16 accepted; `tready`=0 from the cycle after the 16th push; `fifo_level`=16. One frame → `tready` returns to 1 and the 17th word is accepted.
- Push 0xFFF, raise CS after 6 SCLK falling edges → `abort_count`=1; `spi_data`=0 within 3 cycles; the next frame sends the next queued word or 0x0800.
- Assert `s00_axis_aresetn` mid-frame with 5 words queued → `fifo_level`=0 and `spi_data`=0 asynchronously. After release, a frame captures 0x0800.

Source files
------------

// File: rtl/spi_adc_responder.sv
// spi_adc_responder: SPI responder emulating a 12-bit ADC, fed from an AXI4-Stream sample FIFO
//
// Ports:
//   s00_axis_aclk     system clock, all logic on the rising edge
//   s00_axis_aresetn  asynchronous active-low reset
//   s00_axis_tdata    sample word, low DATA_BITS bits are transmitted
//   s00_axis_tstrb    ignored
//   s00_axis_tvalid   sample word valid
//   s00_axis_tready   high while the FIFO is not full (low during reset)
//   spi_clock         initiator SCLK, asynchronous, oversampled
//   spi_chipselect    initiator CS, active low, asynchronous, oversampled
//   spi_data          registered serial data, MSB first behind leading zeros
//   fifo_level        words currently buffered
//   underflow_count   frames started on an empty FIFO, saturating
//   abort_count       frames ended by CS rise before the last bit, saturating
module spi_adc_responder #(
   parameter int C_S00_AXIS_TDATA_WIDTH = 16,
   parameter int FIFO_ADDR_WIDTH = 4,
   parameter int FRAME_BITS = 16,
   parameter int DATA_BITS = 12,
   parameter logic [DATA_BITS-1:0] IDLE_SAMPLE = 12'h800
) (
   input  logic                                  s00_axis_aclk,
   input  logic                                  s00_axis_aresetn,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
   input  logic                                  s00_axis_tvalid,
   output logic                                  s00_axis_tready,
   input  logic                                  spi_clock,
   input  logic                                  spi_chipselect,
   output logic                                  spi_data,
   output logic [FIFO_ADDR_WIDTH:0]              fifo_level,
   output logic [7:0]                            underflow_count,
   output logic [7:0]                            abort_count
);
   localparam int DEPTH = 2**FIFO_ADDR_WIDTH;
   localparam int CW = $clog2(FRAME_BITS);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t state;
   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic full, empty, push, pop;
   logic sclk_s1, sclk_s2, sclk_h, cs_s1, cs_s2, cs_h;
   logic sclk_fall, cs_fall, cs_rise;
   logic [FRAME_BITS-1:0] shreg, load_word;
   logic [CW-1:0] bit_cnt;
   logic unused;

   assign unused = ^{s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:DATA_BITS], shreg[FRAME_BITS-1]};

   assign full = fifo_level == (FIFO_ADDR_WIDTH+1)'(DEPTH);
   assign empty = fifo_level == '0;
   // tready is gated by reset so the initiator sees it low until the first cycle after release
   assign s00_axis_tready = s00_axis_aresetn & ~full;
   assign push = s00_axis_tvalid & s00_axis_tready;
   // cs_rise is checked first in the FSM, so a pop only ever happens on a real frame load
   assign pop = state == IDLE && cs_fall && !cs_rise && !empty;

   // edges compare the second sync stage against a history flop
   assign sclk_fall = sclk_h & ~sclk_s2;
   assign cs_fall = cs_h & ~cs_s2;
   assign cs_rise = ~cs_h & cs_s2;

   assign load_word = FRAME_BITS'(empty ? IDLE_SAMPLE : mem[rd_ptr]);

   always_ff @(posedge s00_axis_aclk)
      if (push) mem[wr_ptr] <= s00_axis_tdata[DATA_BITS-1:0];

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn)
      if (!s00_axis_aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) fifo_level <= fifo_level + 1'b1;
         else if (pop && !push) fifo_level <= fifo_level - 1'b1;
      end

   // sync chains preset high so releasing reset with CS idle never looks like a frame start
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn)
      if (!s00_axis_aresetn) begin
         {sclk_s1, sclk_s2, sclk_h} <= '1;
         {cs_s1, cs_s2, cs_h} <= '1;
      end else begin
         {sclk_s1, sclk_s2, sclk_h} <= {spi_clock, sclk_s1, sclk_s2};
         {cs_s1, cs_s2, cs_h} <= {spi_chipselect, cs_s1, cs_s2};
      end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn)
      if (!s00_axis_aresetn) begin
         state <= IDLE;
         shreg <= '0;
         bit_cnt <= '0;
         spi_data <= 1'b0;
         underflow_count <= '0;
         abort_count <= '0;
      end else if (cs_rise) begin
         spi_data <= 1'b0;
         state <= IDLE;
         if (state == SHIFT && abort_count != 8'hFF) abort_count <= abort_count + 1'b1;
      end else begin
         case (state)
            IDLE: begin
               spi_data <= 1'b0;
               if (cs_fall) begin
                  shreg <= load_word;
                  spi_data <= load_word[FRAME_BITS-1];
                  bit_cnt <= '0;
                  state <= SHIFT;
                  if (empty && underflow_count != 8'hFF) underflow_count <= underflow_count + 1'b1;
               end
            end
            SHIFT:
               if (sclk_fall && !cs_s2) begin
                  shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                  spi_data <= shreg[FRAME_BITS-2];
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == CW'(FRAME_BITS-2)) state <= HOLD;
               end
            HOLD:
               if (sclk_fall) spi_data <= 1'b0;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_spi_adc_responder.sv
// tb_spi_adc_responder: scoreboard bench driving AXI-Stream samples and an SPI initiator
module tb_spi_adc_responder;
   logic clk = 1'b0;
   logic rst_n;
   logic [15:0] tdata;
   logic [1:0] tstrb;
   logic tvalid, tready, sclk, cs, sdat;
   logic [4:0] level;
   logic [7:0] ufc, abc;

   int pass_cnt = 0;
   int tot_cnt = 0;
   logic [11:0] model_q[$];
   logic [15:0] exp_q[$];
   int uf_m = 0;
   int ab_m = 0;

   spi_adc_responder dut (
      .s00_axis_aclk(clk),
      .s00_axis_aresetn(rst_n),
      .s00_axis_tdata(tdata),
      .s00_axis_tstrb(tstrb),
      .s00_axis_tvalid(tvalid),
      .s00_axis_tready(tready),
      .spi_clock(sclk),
      .spi_chipselect(cs),
      .spi_data(sdat),
      .fifo_level(level),
      .underflow_count(ufc),
      .abort_count(abc)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tot_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic push_word(input logic [11:0] w);
      logic acc;
      acc = 1'b0;
      tvalid = 1'b1;
      tdata = {4'hA, w};
      for (int i = 0; i < 50 && !acc; i++) begin
         acc = tready;
         @(negedge clk);
      end
      tvalid = 1'b0;
      check("push_accept", {31'd0, acc}, 32'd1);
      if (acc) model_q.push_back(w);
   endtask

   // one SPI frame; abort_after>0 raises CS after that many SCLK falling edges
   task automatic frame(input int hp, input int abort_after);
      logic [15:0] got, e;
      if (model_q.size() > 0) e = {4'h0, model_q.pop_front()};
      else begin
         e = 16'h0800;
         if (uf_m < 255) uf_m++;
      end
      if (abort_after == 0) exp_q.push_back(e);
      got = '0;
      cs = 1'b0;
      tick(hp);
      for (int b = 0; b < 16; b++) begin
         sclk = 1'b1;
         got = {got[14:0], sdat};
         tick(hp);
         sclk = 1'b0;
         tick(hp);
         if (abort_after == b + 1) begin
            check("abort_pre_bit", {31'd0, sdat}, {31'd0, e[15-abort_after]});
            cs = 1'b1;
            if (ab_m < 255) ab_m++;
            tick(3);
            check("abort_sdat_zero", {31'd0, sdat}, 32'd0);
            tick(hp);
            return;
         end
      end
      tick(hp);
      cs = 1'b1;
      tick(hp);
      check("frame_data", {16'd0, got}, {16'd0, exp_q.pop_front()});
   endtask

   initial begin
      int n_acc;
      rst_n = 1'b0;
      tdata = '0;
      tstrb = '0;
      tvalid = 1'b0;
      sclk = 1'b0;
      cs = 1'b1;
      tick(3);
      check("rst_tready", {31'd0, tready}, 32'd0);
      check("rst_sdat", {31'd0, sdat}, 32'd0);
      check("rst_level", {27'd0, level}, 32'd0);
      check("rst_ufc", {24'd0, ufc}, 32'd0);
      check("rst_abc", {24'd0, abc}, 32'd0);
      rst_n = 1'b1;
      tick(1);
      check("tready_after_rst", {31'd0, tready}, 32'd1);

      push_word(12'hABC);
      check("level_one", {27'd0, level}, 32'd1);
      frame(8, 0);
      check("level_zero", {27'd0, level}, 32'd0);
      check("ufc_zero", {24'd0, ufc}, uf_m);
      check("abc_zero", {24'd0, abc}, ab_m);

      frame(8, 0);
      check("ufc_one", {24'd0, ufc}, uf_m);
      for (int i = 0; i < 300; i++) frame(4, 0);
      check("ufc_sat", {24'd0, ufc}, uf_m);

      push_word(12'h123);
      push_word(12'h456);
      push_word(12'h789);
      check("level_three", {27'd0, level}, 32'd3);
      repeat (3) frame(8, 0);

      n_acc = 0;
      tvalid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tdata = {4'h5, 12'(12'h100 + i)};
         if (tready) begin
            model_q.push_back(tdata[11:0]);
            n_acc++;
         end
         @(negedge clk);
      end
      check("full_accepted", n_acc, 32'd16);
      check("full_tready", {31'd0, tready}, 32'd0);
      check("full_level", {27'd0, level}, 32'd16);
      frame(8, 0);
      model_q.push_back(tdata[11:0]);
      check("refill_level", {27'd0, level}, 32'd16);
      check("refill_tready", {31'd0, tready}, 32'd0);
      tvalid = 1'b0;
      repeat (16) frame(4, 0);
      check("drained_level", {27'd0, level}, 32'd0);

      push_word(12'hFFF);
      push_word(12'h0AA);
      frame(8, 6);
      check("abc_one", {24'd0, abc}, ab_m);
      frame(8, 0);
      frame(8, 0);
      check("abc_still_one", {24'd0, abc}, ab_m);

      push_word(12'hFFF);
      for (int i = 0; i < 4; i++) push_word(12'(12'h300 + i));
      check("level_five", {27'd0, level}, 32'd5);
      cs = 1'b0;
      tick(8);
      for (int b = 0; b < 6; b++) begin
         sclk = 1'b1;
         tick(8);
         sclk = 1'b0;
         tick(8);
      end
      check("mid_frame_bit", {31'd0, sdat}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      model_q.delete();
      uf_m = 0;
      ab_m = 0;
      check("async_level", {27'd0, level}, 32'd0);
      check("async_sdat", {31'd0, sdat}, 32'd0);
      check("async_tready", {31'd0, tready}, 32'd0);
      check("async_ufc", {24'd0, ufc}, uf_m);
      check("async_abc", {24'd0, abc}, ab_m);
      cs = 1'b1;
      sclk = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      check("tready_after_rst2", {31'd0, tready}, 32'd1);
      frame(8, 0);
      check("ufc_after_rst", {24'd0, ufc}, uf_m);
      check("abc_after_rst", {24'd0, abc}, ab_m);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
